// File: rtl/byte_mem_responder.sv
// Target-side model of the 8-bit single-port memory bus.
// The address space holds a byte RAM and a 16-byte I/O window. The window
// contains a TX FIFO toward the host, an RX FIFO from the host, a status
// register and a sticky halt flag. Read data is registered with one cycle
// of latency.
module byte_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_wr_i,
  output logic [7:0]  mem_data_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        halt_o
);

  localparam int unsigned PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [3:0] {
    OFF_DATA   = 4'h0,
    OFF_STATUS = 4'h4,
    OFF_HALT   = 4'h8
  } io_off_e;

  logic [7:0] ram [2**ADDR_WIDTH];

  logic [7:0]    tx_buf [FIFO_DEPTH];
  logic [PW-1:0] tx_rd, tx_wr;
  logic [PW:0]   tx_cnt;
  logic [7:0]    rx_buf [FIFO_DEPTH];
  logic [PW-1:0] rx_rd, rx_wr;
  logic [PW:0]   rx_cnt;
  logic          tx_ovf;

  logic [31:0] prev_addr;
  logic [7:0]  prev_data;
  logic        prev_wr;
  logic        prev_valid;

  logic                  io_sel;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            io_off;
  logic                  new_access;
  logic                  tx_full, rx_full, rx_nonempty;
  logic                  tx_push, tx_drop, tx_pop;
  logic                  rx_push, rx_pop;
  logic                  halt_set;
  logic [7:0]            status;

  // Address decode, access qualification and FIFO handshake strobes
  always_comb begin
    io_sel      = (mem_addr_i[31:4] == IO_BASE[31:4]);
    ram_addr    = mem_addr_i[ADDR_WIDTH-1:0];
    io_off      = mem_addr_i[3:0];
    new_access  = !prev_valid || (mem_addr_i != prev_addr) ||
                  (mem_wr_i != prev_wr) || (mem_data_i != prev_data);
    tx_full     = (tx_cnt == CNT_FULL);
    rx_full     = (rx_cnt == CNT_FULL);
    rx_nonempty = (rx_cnt != '0);
    tx_valid_o  = (tx_cnt != '0);
    rx_ready_o  = !rx_full;
    tx_data_o   = tx_valid_o ? tx_buf[tx_rd] : '0;
    status      = {5'b0, tx_ovf, rx_nonempty, tx_full};

    tx_push  = 1'b0;
    tx_drop  = 1'b0;
    rx_pop   = 1'b0;
    halt_set = 1'b0;
    if (io_sel && new_access) begin
      if (mem_wr_i && io_off == OFF_DATA) begin
        tx_push = !tx_full;
        tx_drop = tx_full;
      end
      if (!mem_wr_i && io_off == OFF_DATA) rx_pop = rx_nonempty;
      if (mem_wr_i && io_off == OFF_HALT) halt_set = 1'b1;
    end
    tx_pop  = tx_valid_o && tx_ready_i;
    rx_push = rx_valid_i && !rx_full;
  end

  // Bus tuple of the previous cycle, used to detect a fresh access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_addr  <= '0;
      prev_data  <= '0;
      prev_wr    <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      prev_addr  <= mem_addr_i;
      prev_data  <= mem_data_i;
      prev_wr    <= mem_wr_i;
      prev_valid <= 1'b1;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_wr_i && !io_sel) ram[ram_addr] <= mem_data_i;
  end

  // FIFO storage writes; entries are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (tx_push) tx_buf[tx_wr] <= mem_data_i;
    if (rx_push) rx_buf[rx_wr] <= rx_data_i;
  end

  // TX pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
    end
  end

  // Sticky TX overflow and halt flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      halt_o <= 1'b0;
    end else begin
      if (tx_drop)  tx_ovf <= 1'b1;
      if (halt_set) halt_o <= 1'b1;
    end
  end

  // Registered read data; writes, and held RX-data reads, keep the last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_o <= '0;
    end else if (!mem_wr_i) begin
      if (!io_sel) begin
        mem_data_o <= ram[ram_addr];
      end else begin
        case (io_off)
          OFF_DATA:   if (new_access) mem_data_o <= rx_nonempty ? rx_buf[rx_rd] : '0;
          OFF_STATUS: mem_data_o <= status;
          default:    mem_data_o <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_responder.sv
// Self-checking bench for byte_mem_responder: directed scenarios followed by
// randomized bus/host traffic, compared every cycle against a queue-based model.
module tb_byte_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        wr = 1'b0;
  logic [7:0]  rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        halt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [7:0]  m_mem [int unsigned];
  logic [7:0]  m_txq [$];
  logic [7:0]  m_rxq [$];
  logic        m_ovf, m_halt, m_pv, m_pwr;
  logic [31:0] m_paddr;
  logic [7:0]  m_pdata, m_rd;

  // bytes the host actually took from the DUT
  logic [7:0]  rcvd [$];

  byte_mem_responder #(
    .ADDR_WIDTH(17),
    .IO_BASE(32'h0003_0000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr_i(addr), .mem_data_i(wdata), .mem_wr_i(wr),
    .mem_data_o(rd_data),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .halt_o(halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_txq.delete();
    m_rxq.delete();
    m_ovf = 0; m_halt = 0; m_pv = 0; m_pwr = 0;
    m_paddr = '0; m_pdata = '0; m_rd = '0;
  endtask

  // One bus cycle: update the model from the pre-edge inputs, clock, compare.
  task automatic step();
    bit fresh, io;
    int txn, rxn;
    logic [7:0] st;
    fresh = !m_pv || addr != m_paddr || wr != m_pwr || wdata != m_pdata;
    io    = (addr[31:4] == 28'h0003000);
    txn   = m_txq.size();
    rxn   = m_rxq.size();
    st    = {5'b0, m_ovf, rxn != 0, txn == 8};
    if (tx_ready && txn > 0) void'(m_txq.pop_front());
    if (!io) begin
      if (wr) m_mem[addr & 32'h1FFFF] = wdata;
      else    m_rd = m_mem[addr & 32'h1FFFF];
    end else begin
      case (addr[3:0])
        4'h0: if (wr) begin
                if (fresh) begin
                  if (txn == 8) m_ovf = 1;
                  else m_txq.push_back(wdata);
                end
              end else if (fresh) begin
                m_rd = (rxn > 0) ? m_rxq.pop_front() : 8'h00;
              end
        4'h4: if (!wr) m_rd = st;
        4'h8: if (wr) begin
                if (fresh) m_halt = 1;
              end else m_rd = 8'h00;
        default: if (!wr) m_rd = 8'h00;
      endcase
    end
    if (rx_valid && rxn < 8) m_rxq.push_back(rx_data);
    m_pv = 1; m_paddr = addr; m_pwr = wr; m_pdata = wdata;

    if (tx_valid && tx_ready) rcvd.push_back(tx_data);
    @(posedge clk);
    #1;
    check("mem_data", rd_data, m_rd);
    check("tx_valid", tx_valid, m_txq.size() != 0);
    check("tx_data", tx_data, m_txq.size() != 0 ? m_txq[0] : 8'h00);
    check("rx_ready", rx_ready, m_rxq.size() < 8);
    check("halt", halt, m_halt);
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
    addr = a; wr = w; wdata = d;
    step();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_mem_data", rd_data, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b1);
    check("rst_halt", halt, 1'b0);
    rst = 0;

    // preload the RAM locations the bench reads
    bus(32'h0, 1, 8'h00);
    for (int i = 0; i < 32; i++) bus(32'h100 + i, 1, 8'($urandom));

    // RAM write, read and alias
    bus(32'h100, 1, 8'hA5);
    bus(32'h100, 0, 8'h00);
    check("ram_read", rd_data, 8'hA5);
    bus(32'h0002_0100, 0, 8'h00);
    check("ram_alias", rd_data, 8'hA5);

    // TX: held write merges into one push
    tx_ready = 1;
    rcvd.delete();
    repeat (5) bus(32'h3_0000, 1, 8'h41);
    bus(32'h0, 0, 8'h00);
    bus(32'h3_0000, 1, 8'h42);
    repeat (3) bus(32'h0, 0, 8'h00);
    check("tx_count", rcvd.size(), 2);
    if (rcvd.size() == 2) begin
      check("tx_first", rcvd[0], 8'h41);
      check("tx_second", rcvd[1], 8'h42);
    end
    check("tx_drained", tx_valid, 1'b0);

    // RX: push, status, held read pops once, empty read
    tx_ready = 0;
    rx_data = 8'h55; rx_valid = 1;
    bus(32'h0, 0, 8'h00);
    rx_valid = 0;
    bus(32'h3_0004, 0, 8'h00);
    check("rx_status", rd_data, 8'h02);
    for (int i = 0; i < 4; i++) begin
      bus(32'h3_0000, 0, 8'h00);
      check("rx_hold", rd_data, 8'h55);
    end
    bus(32'h0, 0, 8'h00);
    bus(32'h3_0000, 0, 8'h00);
    check("rx_empty", rd_data, 8'h00);

    // TX overflow
    for (int i = 1; i <= 9; i++) begin
      bus(32'h3_0000, 1, 8'(i));
      bus(32'h0, 0, 8'h00);
    end
    bus(32'h3_0004, 0, 8'h00);
    check("ovf_status", rd_data, 8'h05);
    tx_ready = 1;
    rcvd.delete();
    repeat (10) bus(32'h0, 0, 8'h00);
    check("ovf_count", rcvd.size(), 8);
    for (int i = 0; i < 8 && i < rcvd.size(); i++) check("ovf_byte", rcvd[i], 8'(i + 1));

    // RX simultaneous host push and bus pop
    rx_data = 8'h11; rx_valid = 1;
    bus(32'h0, 0, 8'h00);
    rx_data = 8'h22;
    bus(32'h3_0000, 0, 8'h00);
    check("simul_pop", rd_data, 8'h11);
    rx_valid = 0;
    bus(32'h0, 0, 8'h00);
    bus(32'h3_0000, 0, 8'h00);
    check("simul_next", rd_data, 8'h22);
    bus(32'h0, 0, 8'h00);
    bus(32'h3_0000, 0, 8'h00);
    check("simul_empty", rd_data, 8'h00);

    // halt, then asynchronous reset with both FIFOs occupied
    bus(32'h3_0008, 1, 8'h00);
    check("halt_set", halt, 1'b1);
    tx_ready = 0;
    bus(32'h3_0000, 1, 8'h77);
    rx_data = 8'h33; rx_valid = 1;
    bus(32'h0, 0, 8'h00);
    rx_valid = 0;
    bus(32'h100, 0, 8'h00);
    #3 rst = 1;
    #1;
    check("arst_halt", halt, 1'b0);
    check("arst_mem_data", rd_data, 8'h00);
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_rx_ready", rx_ready, 1'b1);
    model_reset();
    @(posedge clk);
    #2 rst = 0;
    bus(32'h100, 0, 8'h00);
    check("ram_kept", rd_data, 8'hA5);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int unsigned sel;
      logic [31:0] bases [3];
      bases[0] = 32'h0000_0100;
      bases[1] = 32'h0002_0100;
      bases[2] = 32'hFFFE_0100;
      sel      = $urandom_range(0, 19);
      tx_ready = ($urandom_range(0, 3) != 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      if (sel < 7) begin
        addr = bases[$urandom_range(0, 2)] + $urandom_range(0, 31);
        wr = 1'($urandom); wdata = 8'($urandom);
      end else if (sel < 11) begin
        addr = 32'h3_0000; wr = 1'($urandom); wdata = 8'($urandom);
      end else if (sel < 13) begin
        addr = 32'h3_0004; wr = 1'($urandom); wdata = 8'($urandom);
      end else if (sel == 13) begin
        addr = 32'h3_0008; wr = ($urandom_range(0, 7) == 0); wdata = 8'($urandom);
      end else if (sel == 14) begin
        addr = 32'h3_0000 | $urandom_range(1, 15); wr = 1'($urandom); wdata = 8'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_mem_responder.md
Name: byte_mem_responder

Overview:
- Target-side model of the 8-bit, single-port memory bus driven by the CPU memory controller.
- Contains a byte-addressed RAM and a small memory-mapped I/O window:
  - TX byte FIFO toward the host.
  - RX byte FIFO from the host.
  - Status register.
  - Sticky halt flag.
- Read data is registered with exactly one cycle of latency. The initiator samples it two edges after it drives the address.

Parameters:
- ADDR_WIDTH, 17: RAM address bits; RAM depth is 2^ADDR_WIDTH bytes.
- IO_BASE, 32'h00030000: base of the 16-byte I/O window; must be 16-byte aligned.
- FIFO_DEPTH, 8: entries per TX/RX FIFO; must be a power of 2, at least 2.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst, in, 1: asynchronous, active-high reset.
- mem_addr_i, in, 32: bus byte address, held by the initiator.
- mem_data_i, in, 8: write data.
- mem_wr_i, in, 1: 1 = write cycle, 0 = read cycle.
- mem_data_o, out, 8: registered read data.
- tx_data_o, out, 8: head of the TX FIFO.
- tx_valid_o, out, 1: TX FIFO non-empty.
- tx_ready_i, in, 1: host accepts tx_data_o on a posedge when tx_valid_o is 1.
- rx_data_i, in, 8: host byte to push into the RX FIFO.
- rx_valid_i, in, 1: host push request.
- rx_ready_o, out, 1: RX FIFO not full; a push happens on a posedge when rx_valid_i and rx_ready_o are both 1.
- halt_o, out, 1: sticky halt request to the testbench/SoC.

Behaviour:
- Reset (async, immediate):
  - mem_data_o=0, tx_valid_o=0, tx_data_o=0, rx_ready_o=1, halt_o=0, tx_ovf=0.
  - Both FIFOs empty, pointers and counts 0.
  - prev_valid=0. RAM contents are not reset.
- Decode:
  - io_sel = (mem_addr_i[31:4] == IO_BASE[31:4]).
  - Otherwise the access targets RAM at mem_addr_i[ADDR_WIDTH-1:0]; upper bits are ignored (aliasing).
- RAM:
  - Write: ram[addr] <= mem_data_i on every posedge with mem_wr_i=1.
  - Read: mem_data_o <= ram[addr] on every posedge with mem_wr_i=0.
  - On write cycles mem_data_o holds its value.
- Access qualification: the initiator leaves address, wr and data static between transfers. Registers prev_addr/prev_wr/prev_data/prev_valid capture the tuple every cycle.
  - new_access = !prev_valid OR the tuple differs from the previous cycle.
  - I/O side effects (push, pop, halt) fire only when new_access=1.
  - RAM is not qualified; it is idempotent.
  - Consequence: back-to-back identical I/O writes with no different bus cycle between them merge into one. The initiator guarantees an intervening access, e.g. an instruction fetch.
- I/O map, by offset mem_addr_i[3:0]:
  - 0x0 write: push mem_data_i into TX. If TX is full, drop the byte and set tx_ovf (sticky).
  - 0x0 read: mem_data_o <= RX head. Pop only if non-empty and new_access. If empty, return 0x00 with no pointer change. A held address re-reads the popped value without popping again; mem_data_o holds.
  - 0x4 read: mem_data_o <= {5'b0, tx_ovf, rx_nonempty, tx_full}, values sampled before the edge. Writes are ignored.
  - 0x8 write: halt_o <= 1, sticky until rst. Reads return 0.
  - Other offsets: writes are ignored; reads return 0.
- FIFOs:
  - Circular buffers with wrap-around pointers and a count of width log2(FIFO_DEPTH)+1.
  - tx_data_o is the head entry, combinational from the buffer.
  - Simultaneous push and pop in the same cycle: both occur, count is unchanged, order is preserved. This applies to RX pop with host push, and TX push with host pop.
  - A push to a full FIFO cannot be accepted on the same edge as a pop. Full is evaluated before the edge.
- Latency:
  - An address presented after edge t is sampled at edge t+1.
  - mem_data_o is valid after t+1.
  - Side effects are visible after t+1.

Test Plan:
- RAM: write 0xA5 to 0x00000100, then read 0x100 → mem_data_o=0xA5 one cycle after the read address is sampled. Read 0x00020100 (alias) → 0xA5.
- TX: write 0x41 to 0x30000, hold wr=1 for 5 cycles, read 0x0, then write 0x42 to 0x30000 → host with tx_ready_i=1 receives exactly 0x41, 0x42, then tx_valid_o=0.
- RX:
  - Host pushes 0x55; bus reads 0x30004 → 0x02.
  - Bus reads 0x30000 and holds 4 cycles → 0x55 every cycle, one pop.
  - Bus reads 0x0, then 0x30000 → 0x00.
- Overflow: tx_ready_i=0, 9 distinct writes 0x01..0x09 to 0x30000, interleaved with reads of 0x0 → status 0x05. Then release tx_ready_i → host gets 0x01..0x08; 0x09 is lost.
- Simultaneous: RX holds 1 entry (0x11); in the same cycle the host pushes 0x22 and the bus pops → mem_data_o=0x11, count stays 1, next pop returns 0x22.
- Halt/reset:
  - Write 0x30008 → halt_o=1 after that edge.
  - Assert rst mid-cycle with FIFOs non-empty → halt_o, mem_data_o, tx_valid_o cleared immediately.
  - After reset, reading 0x100 → 0xA5 (RAM preserved).
